// File: rtl/oflow_score_board.sv
// Registration score-board resolver: takes one set of per-lane best matches,
// serially decides reuse-vs-allocate per lane, and pulses the resolved IDs out.
module oflow_score_board #(
    parameter int          NUM_PE  = 4,
    parameter int          SCORE_W = 16,
    parameter int          ID_W    = 12,
    parameter int unsigned THRESH  = 32'h0400
) (
    input  logic                      clk,
    input  logic                      reset_N,
    input  logic                      start_score_board,
    input  logic                      first_frame,
    input  logic                      clear_ids,
    input  logic [NUM_PE-1:0]         valid_mask,
    input  logic [NUM_PE*SCORE_W-1:0] score_in,
    input  logic [NUM_PE*ID_W-1:0]    cand_id_in,
    output logic [NUM_PE*ID_W-1:0]    id_out,
    output logic [NUM_PE-1:0]         new_id_flag,
    output logic                      id_valid,
    output logic                      done_score_board,
    output logic                      busy,
    output logic [ID_W-1:0]           next_id
);

    localparam int                 LCW      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [SCORE_W-1:0] THRESH_V = SCORE_W'(THRESH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_OUT     = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [NUM_PE-1:0]         mask_q;
    logic                      first_q;
    logic [NUM_PE*SCORE_W-1:0] score_q;
    logic [NUM_PE*ID_W-1:0]    cand_q;
    logic [LCW-1:0]            lane_cnt_q, lane_cnt_d;
    logic [NUM_PE*ID_W-1:0]    id_q, id_d;
    logic [NUM_PE-1:0]         new_q, new_d;
    logic [ID_W-1:0]           next_id_q, next_id_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;

    logic                      capture, clear, resolve, last_lane, alloc;
    logic [SCORE_W-1:0]        cur_score;
    logic [ID_W-1:0]           cur_cand, id_inc;
    logic [NUM_PE-1:0]         hit;

    // The done cycle still counts as busy, so start/clear are not accepted then.
    assign capture   = (state_q == ST_IDLE) && !done_q && start_score_board;
    assign clear     = (state_q == ST_IDLE) && !done_q && clear_ids;
    assign resolve   = (state_q == ST_RESOLVE);
    assign last_lane = (lane_cnt_q == LCW'(NUM_PE - 1));

    assign cur_score = score_q[lane_cnt_q*SCORE_W +: SCORE_W];
    assign cur_cand  = cand_q[lane_cnt_q*ID_W +: ID_W];
    assign id_inc    = (next_id_q == '1) ? ID_W'(1) : next_id_q + ID_W'(1);

    // An earlier lane that kept its candidate owns that ID for this set.
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_conflict
        assign hit[gi] = (LCW'(gi) < lane_cnt_q) && mask_q[gi] && !new_q[gi] &&
                         (id_q[gi*ID_W +: ID_W] == cur_cand);
    end

    assign alloc = mask_q[lane_cnt_q] &&
                   (first_q || (cur_score >= THRESH_V) || (cur_cand == '0) || (|hit));

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        id_d       = id_q;
        new_d      = new_q;
        next_id_d  = next_id_q;
        if (clear) begin
            next_id_d = ID_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d    = ST_RESOLVE;
                    lane_cnt_d = '0;
                    id_d       = '0;
                    new_d      = '0;
                end
            end
            ST_RESOLVE: begin
                id_d[lane_cnt_q*ID_W +: ID_W] = alloc ? next_id_q :
                                                (mask_q[lane_cnt_q] ? cur_cand : '0);
                new_d[lane_cnt_q] = alloc;
                if (alloc) begin
                    next_id_d = id_inc;
                end
                lane_cnt_d = lane_cnt_q + LCW'(1);
                if (last_lane) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_q == ST_OUT);
        busy_d = (state_d != ST_IDLE) || (state_q == ST_OUT);
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            first_q    <= 1'b0;
            score_q    <= '0;
            cand_q     <= '0;
            lane_cnt_q <= '0;
            id_q       <= '0;
            new_q      <= '0;
            next_id_q  <= ID_W'(1);
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            id_q       <= id_d;
            new_q      <= new_d;
            next_id_q  <= next_id_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            if (capture) begin
                mask_q  <= valid_mask;
                first_q <= first_frame;
                score_q <= score_in;
                cand_q  <= cand_id_in;
            end
        end
    end

    assign id_out           = id_q;
    assign new_id_flag      = new_q;
    assign id_valid         = done_q;
    assign done_score_board = done_q;
    assign busy             = busy_q;
    assign next_id          = next_id_q;

endmodule

// File: tb/tb_oflow_score_board.sv
// Scoreboard bench for oflow_score_board: a lane-rule model queues expected
// results at each start; a monitor pops and compares on every id_valid pulse.
module tb_oflow_score_board;

    logic        clk;
    logic        reset_N;
    logic        start_score_board;
    logic        first_frame;
    logic        clear_ids;
    logic [3:0]  valid_mask;
    logic [63:0] score_in;
    logic [47:0] cand_id_in;
    logic [47:0] id_out;
    logic [3:0]  new_id_flag;
    logic        id_valid;
    logic        done_score_board;
    logic        busy;
    logic [11:0] next_id;

    oflow_score_board #(
        .NUM_PE(4), .SCORE_W(16), .ID_W(12), .THRESH(32'h0400)
    ) dut (
        .clk(clk),
        .reset_N(reset_N),
        .start_score_board(start_score_board),
        .first_frame(first_frame),
        .clear_ids(clear_ids),
        .valid_mask(valid_mask),
        .score_in(score_in),
        .cand_id_in(cand_id_in),
        .id_out(id_out),
        .new_id_flag(new_id_flag),
        .id_valid(id_valid),
        .done_score_board(done_score_board),
        .busy(busy),
        .next_id(next_id)
    );

    typedef struct {
        logic [47:0] ids;
        logic [3:0]  nw;
        logic [11:0] nid;
        int          cap;
    } exp_t;

    exp_t        sb_q[$];
    logic [11:0] model_nid = 12'd1;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference lane rules, in priority order, with sequential allocation.
    task automatic model_set(input logic [3:0] m, input logic [63:0] sc,
                             input logic [47:0] cd, input bit ff, input bit clr,
                             input int cap);
        exp_t        e;
        logic [11:0] nid;
        logic [15:0] s;
        logic [11:0] c;
        bit          conf;
        nid   = clr ? 12'd1 : model_nid;
        e.ids = '0;
        e.nw  = '0;
        for (int i = 0; i < 4; i++) begin
            s    = sc[i*16 +: 16];
            c    = cd[i*12 +: 12];
            conf = 1'b0;
            for (int j = 0; j < i; j++)
                if (m[j] && !e.nw[j] && (cd[j*12 +: 12] == c)) conf = 1'b1;
            if (m[i]) begin
                if (ff || (s >= 16'h0400) || (c == 12'd0) || conf) begin
                    e.ids[i*12 +: 12] = nid;
                    e.nw[i]           = 1'b1;
                    nid = (nid == 12'hFFF) ? 12'd1 : nid + 12'd1;
                end else begin
                    e.ids[i*12 +: 12] = c;
                end
            end
        end
        e.nid     = nid;
        e.cap     = cap;
        model_nid = nid;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_N && done_score_board) begin
            if (sb_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done id_out=%h required no output", id_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_vec++;
                if (id_out !== e.ids) begin
                    n_err++;
                    $display("FAIL id_out got=%h exp=%h", id_out, e.ids);
                end
                n_vec++;
                if (new_id_flag !== e.nw) begin
                    n_err++;
                    $display("FAIL new_id_flag got=%b exp=%b", new_id_flag, e.nw);
                end
                n_vec++;
                if (next_id !== e.nid) begin
                    n_err++;
                    $display("FAIL next_id got=%0d exp=%0d", next_id, e.nid);
                end
                n_vec++;
                if ((cyc - e.cap) !== 5) begin
                    n_err++;
                    $display("FAIL latency got=%0d exp=5", cyc - e.cap);
                end
                n_vec++;
                if ({id_valid, busy} !== 2'b11) begin
                    n_err++;
                    $display("FAIL valid_busy_at_done got=%b exp=11", {id_valid, busy});
                end
                $display("set done: ids=%h new=%b next_id=%0d", id_out, new_id_flag, next_id);
            end
        end
    end

    task automatic run_set(input logic [3:0] m, input logic [63:0] sc,
                           input logic [47:0] cd, input bit ff, input bit clr,
                           input int restart_at, output bit got);
        got = 1'b0;
        @(negedge clk);
        valid_mask        = m;
        score_in          = sc;
        cand_id_in        = cd;
        first_frame       = ff;
        clear_ids         = clr;
        start_score_board = 1'b1;
        model_set(m, sc, cd, ff, clr, cyc + 1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start_score_board = (k == restart_at);
            clear_ids         = 1'b0;
            if (done_score_board) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_N = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({id_out, new_id_flag, id_valid, done_score_board, busy} !== 55'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0", {id_out, new_id_flag, id_valid, done_score_board, busy});
        end
        n_vec++;
        if (next_id !== 12'd1) begin
            n_err++;
            $display("FAIL reset_next_id got=%0d exp=1", next_id);
        end
        reset_N = 1'b1;
    endtask

    task automatic test_first_frame();
        bit got;
        run_set(4'b1111, {4{16'h0010}}, 48'd0, 1'b1, 1'b0, 0, got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL first_frame_done got=timeout exp=done"); end
    endtask

    task automatic test_match();
        bit got;
        run_set(4'b1111, {4{16'h0010}}, {12'd10, 12'd9, 12'd8, 12'd7}, 1'b0, 1'b0, 0, got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL match_done got=timeout exp=done"); end
    endtask

    task automatic test_threshold();
        bit got;
        run_set(4'b0011, {16'h0010, 16'h0010, 16'h0400, 16'h03FF},
                {12'd0, 12'd0, 12'd21, 12'd20}, 1'b0, 1'b0, 0, got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL threshold_done got=timeout exp=done"); end
    endtask

    task automatic test_conflict();
        bit got;
        run_set(4'b1111, {4{16'h0001}}, {12'd30, 12'd30, 12'd31, 12'd30}, 1'b0, 1'b0, 0, got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL conflict_done got=timeout exp=done"); end
    endtask

    task automatic test_wrap_clear();
        bit   got;
        int   n;
        logic [3:0] m;
        while (model_nid != 12'hFFF) begin
            n = 4095 - int'(model_nid);
            m = (n >= 4) ? 4'hF : 4'((1 << n) - 1);
            run_set(m, {4{16'h0010}}, 48'd0, 1'b1, 1'b0, 0, got);
            if (!got) begin
                n_vec++; n_err++;
                $display("FAIL fill_done got=timeout exp=done");
                break;
            end
        end
        run_set(4'b0011, {4{16'hFFFF}}, {12'd0, 12'd0, 12'd6, 12'd5}, 1'b0, 1'b0, 0, got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL wrap_done got=timeout exp=done"); end
        run_set(4'b0101, {4{16'h0010}}, {12'd0, 12'd0, 12'd0, 12'd0}, 1'b0, 1'b1, 0, got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL clear_start_done got=timeout exp=done"); end
    endtask

    task automatic test_double_start();
        bit got;
        int extra;
        run_set(4'b1111, {4{16'h0001}}, {12'd44, 12'd43, 12'd42, 12'd41}, 1'b0, 1'b0, 2, got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL double_start_done got=timeout exp=done"); end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_score_board) extra++;
        end
        n_vec++;
        if (extra !== 0) begin n_err++; $display("FAIL double_start_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        exp_t dropped;
        int   dones;
        @(negedge clk);
        valid_mask        = 4'b1111;
        score_in          = {4{16'h0010}};
        cand_id_in        = 48'd0;
        first_frame       = 1'b1;
        start_score_board = 1'b1;
        model_set(4'b1111, {4{16'h0010}}, 48'd0, 1'b1, 1'b0, cyc + 1);
        @(negedge clk);
        start_score_board = 1'b0;
        @(negedge clk);
        reset_N = 1'b0;
        #1;
        dropped   = sb_q.pop_back();
        model_nid = 12'd1;
        n_vec++;
        if ({id_out, new_id_flag, id_valid, done_score_board, busy} !== 55'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got=%h exp=0", {id_out, new_id_flag, id_valid, done_score_board, busy});
        end
        n_vec++;
        if (next_id !== 12'd1) begin
            n_err++;
            $display("FAIL midreset_next_id got=%0d exp=1 (dropped nid %0d)", next_id, dropped.nid);
        end
        @(negedge clk);
        reset_N = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_score_board) dones++;
        end
        n_vec++;
        if (dones !== 0) begin n_err++; $display("FAIL midreset_done got=%0d exp=0", dones); end
    endtask

    task automatic test_after_reset();
        bit got;
        run_set(4'b0101, {4{16'h0010}}, 48'd0, 1'b1, 1'b0, 0, got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL after_reset_done got=timeout exp=done"); end
    endtask

    initial begin
        reset_N           = 1'b0;
        start_score_board = 1'b0;
        first_frame       = 1'b0;
        clear_ids         = 1'b0;
        valid_mask        = '0;
        score_in          = '0;
        cand_id_in        = '0;
        test_reset();
        test_first_frame();
        test_match();
        test_threshold();
        test_conflict();
        test_wrap_clear();
        test_double_start();
        test_reset_mid();
        test_after_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (sb_q.size() !== 0) begin
            n_err++;
            $display("FAIL pending_results got=%0d exp=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
